game_countdown_timer: RTL and testbench
=======================================

# game_countdown_timer

Per-round countdown timer that produces the two BCD digits (tens, ones) shown by the on-screen timer digit bitmaps. The on-screen mux/priority stage composes those digits with the "TIME" letters. The block holds a seconds prescaler and a run/pause/expire state machine. It signals end of round to the game controller and raises a low-time flag that drives digit blinking.

## Interface
- CLK_FREQ_HZ, 31_500_000: clk cycles per second; prescaler terminal count is CLK_FREQ_HZ-1.
- START_SECONDS, 99: value loaded on start, range 1..99.
- BONUS_SECONDS, 10: seconds added per bonus pulse, range 1..99.
- LOW_TIME_THRESHOLD, 10: lowTime is asserted while the value is ≤ this and the block is in RUN or PAUSED.
- clk  in  1  system/pixel clock.
- resetN  in  1  asynchronous, active-low reset.
- startGame  in  1  one-cycle pulse: reload START_SECONDS and enter RUN, from any state.
- pause  in  1  level: while high, RUN moves to PAUSED; while low, PAUSED moves back to RUN.
- bonusPulse  in  1  one-cycle pulse: add BONUS_SECONDS. Only active with TIMER_BONUS_EN.
- tensDigit  out  4  BCD tens digit, 0..9.
- onesDigit  out  4  BCD ones digit, 0..9.
- oneSecPulse  out  1  one-cycle pulse on each decrement.
- timeUp  out  1  one-cycle pulse when the count reaches 00.
- running  out  1  high in RUN only.
- lowTime  out  1  low-time warning level.

## Operation
- States:
  - IDLE (reset state): digits hold START_SECONDS; prescaler cleared.
  - RUN: prescaler counts.
  - PAUSED: prescaler and digits frozen.
  - EXPIRED: digits held at 00.
- Transitions:
  - any state + startGame → RUN. Digits reload and the prescaler clears to 0. startGame overrides every other input in that cycle.
  - RUN + pause → PAUSED. PAUSED + !pause → RUN, with the prescaler resuming from its frozen value.
  - RUN + decrement from 01 to 00 → EXPIRED, with timeUp pulsed.
  - EXPIRED and IDLE ignore pause and bonusPulse.
- Prescaler:
  - Width is $clog2(CLK_FREQ_HZ).
  - Increments in RUN only.
  - At CLK_FREQ_HZ-1 it wraps to 0 and produces a tick.
- On tick, the digits decrement in BCD:
  - ones ≠ 0: ones−1.
  - ones = 0: ones ← 9 and tens−1.
- Bonus (macro on, RUN or PAUSED): value ← min(99, value + BONUS_SECONDS), computed in BCD with carry from ones to tens and saturating at 99.
- Tick and bonus in the same cycle: value ← min(99, value − 1 + BONUS_SECONDS). oneSecPulse fires; timeUp does not. A value of 01 therefore does not expire in that cycle.
- Digits are always valid BCD. No value outside 00..99 is ever presented.

## Timing
- Reset values:
  - state = IDLE.
  - tensDigit/onesDigit = BCD(START_SECONDS); with the default, 9/9.
  - prescaler = 0.
  - oneSecPulse, timeUp, running = 0.
  - lowTime = 0.
- All outputs are registered, and all updates happen on the rising clk edge.
- tick → digits, oneSecPulse and timeUp change on the same edge as the prescaler wrap.
- startGame sampled at edge N: running = 1 and reloaded digits are visible after edge N. The first oneSecPulse follows CLK_FREQ_HZ RUN cycles later.
- pause sampled at edge N: from edge N onward, no prescaler advance occurs.
- resetN assertion mid-count clears immediately and asynchronously to the reset values. Deassertion is synchronous-safe; no pulse is generated on release.
- timeUp is high for exactly one cycle per round. It does not re-fire in EXPIRED.

## Configuration
- TIMER_BONUS_EN defined: bonusPulse behaves as described above, with BCD add and saturation.
- TIMER_BONUS_EN undefined: the bonusPulse port still exists but is ignored and no adder logic is built. The tick/bonus-collision rule reduces to a plain decrement.

## Test plan
- Reset check, with CLK_FREQ_HZ=10 and START_SECONDS=12:
  - Assert resetN=0 → digits 1/2, running=0, all pulses 0.
  - Pulse startGame → running=1, and the first oneSecPulse arrives 10 cycles later with digits 1/1.
- Borrow: from 10, one tick → 0/9. lowTime rises once the value is ≤10 with LOW_TIME_THRESHOLD=10. Verify it is high at 10 and at 09.
- Expiry: run from 02 → after 20 cycles, digits 0/0, timeUp pulses once and state is EXPIRED. A further 50 cycles → no pulses. startGame → 1/2 and running again.
- Pause: pause=1 for 37 cycles mid-second at prescaler=4 → digits and prescaler frozen. After release, the next tick arrives exactly 6 cycles later.
- Bonus, with TIMER_BONUS_EN defined:
  - Bonus at 95 → 99 (saturated). Bonus at 07 → 17.
  - Bonus coinciding with a tick at 01 → 10, with oneSecPulse=1 and timeUp=0.
  - With the macro undefined, the same stimulus at 07 → normal decrement only.
- Async reset mid-count at 05, prescaler 7 → immediate return to IDLE with digits 1/2 and prescaler 0. No timeUp on release.

Source files
------------

// File: rtl/game_countdown_timer.sv
// game_countdown_timer
// Per-round countdown timer producing two BCD digits for the on-screen timer.
// It contains a seconds prescaler and an IDLE/RUN/PAUSED/EXPIRED state machine.
//
// Optional feature macro: TIMER_BONUS_EN
//   defined   -> bonusPulse adds BONUS_SECONDS (BCD add, saturating at 99)
//   undefined -> bonusPulse is ignored and no adder is built
//
// Ports:
//   clk          system/pixel clock
//   resetN       asynchronous active-low reset
//   startGame    pulse: reload START_SECONDS and run (overrides everything)
//   pause        level: freezes the prescaler and digits while running
//   bonusPulse   pulse: add bonus seconds (TIMER_BONUS_EN only)
//   tensDigit    BCD tens digit
//   onesDigit    BCD ones digit
//   oneSecPulse  one-cycle pulse on each decrement
//   timeUp       one-cycle pulse when the count reaches 00
//   running      high in RUN only
//   lowTime      value <= LOW_TIME_THRESHOLD while in RUN or PAUSED
module game_countdown_timer #(
    parameter int unsigned CLK_FREQ_HZ        = 31_500_000,
    parameter int unsigned START_SECONDS      = 99,
    parameter int unsigned BONUS_SECONDS      = 10,
    parameter int unsigned LOW_TIME_THRESHOLD = 10
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startGame,
    input  logic       pause,
    input  logic       bonusPulse,
    output logic [3:0] tensDigit,
    output logic [3:0] onesDigit,
    output logic       oneSecPulse,
    output logic       timeUp,
    output logic       running,
    output logic       lowTime
);
    localparam int unsigned PRESC_W = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_FREQ_HZ - 1);
    localparam logic [3:0] START_TENS = 4'(START_SECONDS / 10);
    localparam logic [3:0] START_ONES = 4'(START_SECONDS % 10);
    localparam logic [6:0] LOW_LIMIT  = 7'((LOW_TIME_THRESHOLD > 99) ? 99 : LOW_TIME_THRESHOLD);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

    state_t             state_q, state_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [3:0]         tens_q, tens_d;
    logic [3:0]         ones_q, ones_d;
    logic               one_sec_pulse_q, one_sec_pulse_d;
    logic               time_up_q, time_up_d;
    logic               running_q, running_d;
    logic               low_time_q, low_time_d;

    logic       advance, tick, bonus_hit, expire;
    logic [3:0] dec_tens, dec_ones;
    logic [3:0] base_tens, base_ones;
    logic [3:0] new_tens, new_ones;
    logic [6:0] next_value;

    // startGame wins over everything, so it suppresses advance and bonus.
    assign advance = !startGame && (state_q == RUN) && !pause;
    assign tick    = advance && (presc_q == PRESC_MAX);

    // BCD decrement; only used on a tick, when the value is at least 01.
    always_comb begin
        if (ones_q == 4'd0) begin
            dec_tens = tens_q - 4'd1;
            dec_ones = 4'd9;
        end else begin
            dec_tens = tens_q;
            dec_ones = ones_q - 4'd1;
        end
    end

    assign base_tens = tick ? dec_tens : tens_q;
    assign base_ones = tick ? dec_ones : ones_q;

`ifdef TIMER_BONUS_EN
    localparam logic [4:0] BONUS_TENS = 5'(BONUS_SECONDS / 10);
    localparam logic [4:0] BONUS_ONES = 5'(BONUS_SECONDS % 10);

    logic [4:0] sum_ones, sum_tens;
    logic       carry;

    assign bonus_hit = !startGame && bonusPulse && ((state_q == RUN) || (state_q == PAUSED));

    // Bonus is added after any same-cycle decrement, so a tick at 01 plus a
    // bonus lands on the bonus value instead of expiring.
    always_comb begin
        sum_ones = {1'b0, base_ones} + BONUS_ONES;
        carry    = (sum_ones > 5'd9);
        sum_tens = {1'b0, base_tens} + BONUS_TENS + {4'd0, carry};
        new_tens = base_tens;
        new_ones = base_ones;
        if (bonus_hit) begin
            if (sum_tens > 5'd9) begin
                new_tens = 4'd9;
                new_ones = 4'd9;
            end else begin
                new_tens = sum_tens[3:0];
                new_ones = carry ? 4'(sum_ones - 5'd10) : sum_ones[3:0];
            end
        end
    end
`else
    localparam int unsigned bonus_seconds_unused = BONUS_SECONDS;
    logic bonus_pulse_unused;

    assign bonus_pulse_unused = bonusPulse;
    assign bonus_hit          = 1'b0;
    assign new_tens           = base_tens;
    assign new_ones           = base_ones;
`endif

    assign expire = tick && !bonus_hit && (new_tens == 4'd0) && (new_ones == 4'd0);

    // State register plus datapath registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q         <= IDLE;
            presc_q         <= '0;
            tens_q          <= START_TENS;
            ones_q          <= START_ONES;
            one_sec_pulse_q <= 1'b0;
            time_up_q       <= 1'b0;
            running_q       <= 1'b0;
            low_time_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            presc_q         <= presc_d;
            tens_q          <= tens_d;
            ones_q          <= ones_d;
            one_sec_pulse_q <= one_sec_pulse_d;
            time_up_q       <= time_up_d;
            running_q       <= running_d;
            low_time_q      <= low_time_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (startGame) begin
            state_d = RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (expire)     state_d = EXPIRED;
                    else if (pause) state_d = PAUSED;
                end
                PAUSED: begin
                    if (!pause)     state_d = RUN;
                end
                default: ;
            endcase
        end
    end

    // Prescaler and digit next values.
    always_comb begin
        presc_d = presc_q;
        tens_d  = new_tens;
        ones_d  = new_ones;
        if (advance) presc_d = tick ? '0 : presc_q + PRESC_W'(1);
        if (startGame) begin
            presc_d = '0;
            tens_d  = START_TENS;
            ones_d  = START_ONES;
        end
    end

    // Registered outputs, computed from the next state so they align with it.
    always_comb begin
        next_value      = 7'(tens_d) * 7'd10 + 7'(ones_d);
        running_d       = (state_d == RUN);
        one_sec_pulse_d = tick;
        time_up_d       = expire;
        low_time_d      = ((state_d == RUN) || (state_d == PAUSED)) && (next_value <= LOW_LIMIT);
    end

    assign tensDigit   = tens_q;
    assign onesDigit   = ones_q;
    assign oneSecPulse = one_sec_pulse_q;
    assign timeUp      = time_up_q;
    assign running     = running_q;
    assign lowTime     = low_time_q;

endmodule

// File: tb/tb_game_countdown_timer.sv
module tb_game_countdown_timer;
    localparam int CLK_HZ = 10;
    localparam int START  = 12;
    localparam int BONUS  = 10;
    localparam int LOW_TH = 10;
`ifdef TIMER_BONUS_EN
    localparam bit BONUS_ON = 1'b1;
`else
    localparam bit BONUS_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       resetN, startGame, pause, bonusPulse;
    logic [3:0] tensDigit, onesDigit;
    logic       oneSecPulse, timeUp, running, lowTime;

    always #5 clk = ~clk;

    game_countdown_timer #(
        .CLK_FREQ_HZ(CLK_HZ),
        .START_SECONDS(START),
        .BONUS_SECONDS(BONUS),
        .LOW_TIME_THRESHOLD(LOW_TH)
    ) dut (
        .clk(clk),
        .resetN(resetN),
        .startGame(startGame),
        .pause(pause),
        .bonusPulse(bonusPulse),
        .tensDigit(tensDigit),
        .onesDigit(onesDigit),
        .oneSecPulse(oneSecPulse),
        .timeUp(timeUp),
        .running(running),
        .lowTime(lowTime)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: value as an integer, cycles accrued in the current second.
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;
    int m_val, m_cnt, m_mode;
    bit m_sec, m_up;

    function automatic void model_reset();
        m_mode = M_IDLE; m_val = START; m_cnt = 0; m_sec = 0; m_up = 0;
    endfunction

    function automatic void model_step(input bit st, input bit pa, input bit bo);
        bit tk, bon;
        m_sec = 0; m_up = 0;
        if (st) begin
            m_mode = M_RUN; m_val = START; m_cnt = 0;
        end else begin
            bon = BONUS_ON && bo && (m_mode == M_RUN || m_mode == M_PAUSED);
            tk  = 0;
            if (m_mode == M_RUN && !pa) begin
                m_cnt++;
                if (m_cnt == CLK_HZ) begin m_cnt = 0; tk = 1; end
            end
            if (tk) begin m_sec = 1; m_val--; end
            if (bon) m_val = (m_val + BONUS > 99) ? 99 : m_val + BONUS;
            if (tk && m_val == 0) begin m_up = 1; m_mode = M_DONE; end
            else if (m_mode == M_RUN && pa) m_mode = M_PAUSED;
            else if (m_mode == M_PAUSED && !pa) m_mode = M_RUN;
        end
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        check("tens", {4'd0, tensDigit}, 8'(m_val / 10));
        check("ones", {4'd0, onesDigit}, 8'(m_val % 10));
        check("oneSecPulse", {7'd0, oneSecPulse}, {7'd0, m_sec});
        check("timeUp", {7'd0, timeUp}, {7'd0, m_up});
        check("running", {7'd0, running}, {7'd0, (m_mode == M_RUN)});
        check("lowTime", {7'd0, lowTime},
              {7'd0, ((m_mode == M_RUN || m_mode == M_PAUSED) && m_val <= LOW_TH)});
    endtask

    task automatic cycle(input bit st, input bit pa, input bit bo);
        @(negedge clk);
        startGame = st; pause = pa; bonusPulse = bo;
        @(posedge clk);
        model_step(st, pa, bo);
        #1;
        check_model();
    endtask

    task automatic check_digits(input string name, input int t, input int o);
        check({name, "_tens"}, {4'd0, tensDigit}, 8'(t));
        check({name, "_ones"}, {4'd0, onesDigit}, 8'(o));
    endtask

    task automatic run_to(input int target);
        int n = 0;
        while (!(m_sec && m_val == target) && n < 2000) begin
            cycle(0, 0, 0);
            n++;
        end
        check_digits("run_to", target / 10, target % 10);
    endtask

    task automatic wait_tick(input string name, input int exp_n);
        int n = 0;
        do begin
            cycle(0, 0, 0);
            n++;
        end while (!oneSecPulse && n < 30);
        check(name, 8'(n), 8'(exp_n));
    endtask

    typedef struct {
        bit st, pa, bo;
        int reps;
        int t, o;
        bit sec, up, run, low;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input bit st, input bit pa, input bit bo, input int reps,
                                input int t, input int o,
                                input bit sec, input bit up, input bit run, input bit low);
        vec_t v;
        v.st = st; v.pa = pa; v.bo = bo; v.reps = reps;
        v.t = t; v.o = o; v.sec = sec; v.up = up; v.run = run; v.low = low;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit rp, st, bo;
        resetN = 1'b0; startGame = 1'b0; pause = 1'b0; bonusPulse = 1'b0;
        model_reset();

        // Reset state
        #12;
        check_model();
        check_digits("reset", 1, 2);
        check("reset_running", {7'd0, running}, 8'd0);
        check("reset_pulses", {6'd0, oneSecPulse, timeUp}, 8'd0);
        @(negedge clk);
        resetN = 1'b1;

        // Directed table: {st, pa, bo, reps, tens, ones, sec, up, run, low}
        vecs.push_back(mk(0, 0, 1,  3, 1, 2, 0, 0, 0, 0)); // IDLE ignores bonus
        vecs.push_back(mk(1, 0, 0,  1, 1, 2, 0, 0, 1, 0)); // start
        vecs.push_back(mk(0, 0, 0,  9, 1, 2, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0,  1, 1, 1, 1, 0, 1, 0)); // first tick after 10
        vecs.push_back(mk(0, 0, 0, 10, 1, 0, 1, 0, 1, 1)); // low at 10
        vecs.push_back(mk(0, 0, 0, 10, 0, 9, 1, 0, 1, 1)); // borrow
        vecs.push_back(mk(0, 1, 0,  4, 0, 9, 0, 0, 0, 1)); // paused
        vecs.push_back(mk(0, 0, 0,  1, 0, 9, 0, 0, 1, 1)); // resume
        vecs.push_back(mk(0, 0, 0,  9, 0, 9, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0,  1, 0, 8, 1, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 60, 0, 2, 1, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 19, 0, 1, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0,  1, 0, 0, 1, 1, 0, 0)); // expire
        vecs.push_back(mk(0, 0, 0,  1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 50, 0, 0, 0, 0, 0, 0)); // EXPIRED ignores inputs
        vecs.push_back(mk(1, 1, 0,  1, 1, 2, 0, 0, 1, 0)); // start overrides pause
        vecs.push_back(mk(0, 1, 0,  1, 1, 2, 0, 0, 0, 0));

        foreach (vecs[i]) begin
            repeat (vecs[i].reps) cycle(vecs[i].st, vecs[i].pa, vecs[i].bo);
            check_digits($sformatf("vec%0d", i), vecs[i].t, vecs[i].o);
            check($sformatf("vec%0d_sec", i), {7'd0, oneSecPulse}, {7'd0, vecs[i].sec});
            check($sformatf("vec%0d_up", i), {7'd0, timeUp}, {7'd0, vecs[i].up});
            check($sformatf("vec%0d_run", i), {7'd0, running}, {7'd0, vecs[i].run});
            check($sformatf("vec%0d_low", i), {7'd0, lowTime}, {7'd0, vecs[i].low});
        end

        // Pause mid-second at prescaler 4 for 37 cycles
        cycle(0, 0, 0);
        repeat (4) cycle(0, 0, 0);
        repeat (37) cycle(0, 1, 0);
        check_digits("pause_frozen", 1, 2);
        check("pause_running", {7'd0, running}, 8'd0);
        cycle(0, 0, 0);
        wait_tick("pause_resume_latency", 6);
        check_digits("pause_after", 1, 1);

        // Bonus sequence
        cycle(1, 0, 0);
        repeat (9) cycle(0, 0, 1);
`ifdef TIMER_BONUS_EN
        check_digits("bonus_sat_up", 9, 9);
        run_to(95);
        cycle(0, 0, 1);
        check_digits("bonus_95", 9, 9);
`else
        check_digits("bonus_ignored", 1, 2);
`endif
        run_to(7);
        cycle(0, 0, 1);
`ifdef TIMER_BONUS_EN
        check_digits("bonus_07", 1, 7);
`else
        check_digits("bonus_07", 0, 7);
`endif
        run_to(1);
        repeat (9) cycle(0, 0, 0);
        cycle(0, 0, 1);
        check("bonus_tick_sec", {7'd0, oneSecPulse}, 8'd1);
`ifdef TIMER_BONUS_EN
        check_digits("bonus_tick_01", 1, 0);
        check("bonus_tick_up", {7'd0, timeUp}, 8'd0);
`else
        check_digits("bonus_tick_01", 0, 0);
        check("bonus_tick_up", {7'd0, timeUp}, 8'd1);
`endif

        // Async reset mid-count at 05, prescaler 7
        cycle(1, 0, 0);
        run_to(5);
        repeat (7) cycle(0, 0, 0);
        check_digits("pre_reset", 0, 5);
        #2;
        resetN = 1'b0;
        #1;
        model_reset();
        check_digits("async_reset", 1, 2);
        check("async_reset_running", {7'd0, running}, 8'd0);
        check("async_reset_low", {7'd0, lowTime}, 8'd0);
        @(posedge clk);
        #1;
        check_model();
        @(negedge clk);
        resetN = 1'b1;
        repeat (20) cycle(0, 0, 0);
        cycle(1, 0, 0);
        wait_tick("start_latency", 10);
        check_digits("start_first_tick", 1, 1);

        // Randomized phase against the model
        rp = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) rp = !rp;
            st = ($urandom_range(0, 249) == 0);
            bo = ($urandom_range(0, 14) == 0);
            cycle(st, rp, bo);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
